// File: rtl/sysid_uptime_regs_if.sv
// Avalon-MM slave bus for the system-ID / uptime register block.
// The host drives the strobes and write data; the block returns read data one cycle later.
interface sysid_uptime_regs_if #(
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/sysid_uptime_regs.sv
// System ID, build timestamp, free-running uptime counter with a HI snapshot, a scratch word and a control word.
// Reads have a fixed latency of one cycle. Read data is taken before the write in the same cycle lands.
module sysid_uptime_regs #(
  parameter logic [31:0] SYSTEM_ID = 32'h00000007,
  parameter logic [31:0] TIMESTAMP = 32'd1385042754,
  parameter int          CNT_W     = 48,
  parameter int          ADDR_W    = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  sysid_uptime_regs_if.slave bus
);

  localparam int HI_W = (CNT_W > 32) ? (CNT_W - 32) : 1;

  logic [CNT_W-1:0] cnt_r;
  logic [HI_W-1:0]  hi_r;
  logic [31:0]      scratch_r;
  logic             en_r;
  logic             ovf_r;
  logic [31:0]      readdata_r;
  logic             readdatavalid_r;

  logic [HI_W-1:0]  hi_next_s;
  logic [31:0]      rdata_s;
  logic             wr_scratch_s;
  logic             wr_ctrl_s;
  logic             clr_s;
  logic             wrap_s;
  logic             rd_lo_s;

  // A counter no wider than 32 bits has no upper part, so its snapshot stays zero.
  if (CNT_W > 32) begin : g_hi
    assign hi_next_s = cnt_r[CNT_W-1:32];
  end else begin : g_no_hi
    assign hi_next_s = 1'b0;
  end

  // Address decode of write strobes and counter events.
  always_comb begin
    wr_scratch_s = bus.write && (bus.address == ADDR_W'(4));
    wr_ctrl_s    = bus.write && (bus.address == ADDR_W'(5));
    clr_s        = wr_ctrl_s && bus.writedata[1];
    wrap_s       = en_r && (cnt_r == {CNT_W{1'b1}});
    rd_lo_s      = bus.read && (bus.address == ADDR_W'(2));
  end

  // Read multiplexer on the current register contents.
  always_comb begin
    rdata_s = 32'd0;
    case (bus.address)
      ADDR_W'(0): rdata_s = SYSTEM_ID;
      ADDR_W'(1): rdata_s = TIMESTAMP;
      ADDR_W'(2): rdata_s = 32'(cnt_r);
      ADDR_W'(3): rdata_s = 32'(hi_r);
      ADDR_W'(4): rdata_s = scratch_r;
      ADDR_W'(5): rdata_s = {29'd0, ovf_r, 1'b0, en_r};
      default:    rdata_s = 32'd0;
    endcase
  end

  // Bus response registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      readdata_r      <= 32'd0;
      readdatavalid_r <= 1'b0;
    end else begin
      readdatavalid_r <= bus.read;
      if (bus.read) begin
        readdata_r <= rdata_s;
      end
    end
  end

  // Uptime counter, HI snapshot and control/scratch state. A CLR write beats a
  // simultaneous wrap, and a wrap beats a simultaneous OVF clear.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_r     <= {CNT_W{1'b0}};
      hi_r      <= {HI_W{1'b0}};
      scratch_r <= 32'd0;
      en_r      <= 1'b1;
      ovf_r     <= 1'b0;
    end else begin
      if (clr_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (en_r) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end

      if (clr_s) begin
        hi_r <= {HI_W{1'b0}};
      end else if (rd_lo_s) begin
        hi_r <= hi_next_s;
      end

      if (wr_scratch_s) begin
        scratch_r <= bus.writedata;
      end

      if (wr_ctrl_s) begin
        en_r <= bus.writedata[0];
      end

      if (wrap_s && !clr_s) begin
        ovf_r <= 1'b1;
      end else if (wr_ctrl_s && bus.writedata[2]) begin
        ovf_r <= 1'b0;
      end
    end
  end

  assign bus.readdata      = readdata_r;
  assign bus.readdatavalid = readdatavalid_r;

endmodule

// File: tb/tb_sysid_uptime_regs.sv
// Scoreboard bench: an 8-bit and a 40-bit counter instance receive identical bus traffic.
// A reference model predicts every read, and a separate monitor checks the responses.
module tb_sysid_uptime_regs;

  localparam logic [31:0] SYS_ID = 32'h00000007;
  localparam logic [31:0] TS     = 32'd1385042754;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  sysid_uptime_regs_if #(.ADDR_W(3)) bus_a ();
  sysid_uptime_regs_if #(.ADDR_W(3)) bus_b ();

  sysid_uptime_regs #(.CNT_W(8), .ADDR_W(3)) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(bus_a)
  );
  sysid_uptime_regs #(.CNT_W(40), .ADDR_W(3)) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(bus_b)
  );

  typedef struct {
    int          cyc;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   rst_seen;
  logic [31:0] last_d [2];

  // Reference model state, one slot per instance.
  longint unsigned m_cnt [2];
  longint unsigned m_hi  [2];
  logic [31:0]     m_scr [2];
  bit              m_en  [2];
  bit              m_ovf [2];
  int              m_w   [2] = '{8, 40};

  always @(posedge clock) cyc <= cyc + 1;

  // Advances the model by one bus cycle and queues the expected read response.
  task automatic model_step(input logic rn, input logic rd, input logic wr,
                            input logic [2:0] a, input logic [31:0] wd, input string tag);
    for (int d = 0; d < 2; d++) begin
      longint unsigned lim;
      logic [31:0]     v;
      bit              clr;
      bit              wrap;
      exp_t            e;
      lim = (64'd1 << m_w[d]) - 64'd1;
      if (!rn) begin
        m_cnt[d] = 0; m_hi[d] = 0; m_scr[d] = 32'd0; m_en[d] = 1'b1; m_ovf[d] = 1'b0;
        continue;
      end
      if (rd) begin
        case (a)
          3'd0:    v = SYS_ID;
          3'd1:    v = TS;
          3'd2:    v = m_cnt[d][31:0];
          3'd3:    v = m_hi[d][31:0];
          3'd4:    v = m_scr[d];
          3'd5:    v = {29'd0, m_ovf[d], 1'b0, m_en[d]};
          default: v = 32'd0;
        endcase
        e.cyc = cyc; e.val = v; e.tag = tag;
        if (d == 0) q_a.push_back(e);
        else        q_b.push_back(e);
      end
      clr  = wr && (a == 3'd5) && wd[1];
      wrap = m_en[d] && (m_cnt[d] == lim);
      if (clr)                    m_hi[d] = 0;
      else if (rd && a == 3'd2)   m_hi[d] = m_cnt[d] >> 32;
      if (clr)                    m_cnt[d] = 0;
      else if (m_en[d])           m_cnt[d] = (m_cnt[d] == lim) ? 64'd0 : m_cnt[d] + 64'd1;
      if (wrap && !clr)                  m_ovf[d] = 1'b1;
      else if (wr && a == 3'd5 && wd[2]) m_ovf[d] = 1'b0;
      if (wr && a == 3'd5)        m_en[d]  = wd[0];
      if (wr && a == 3'd4)        m_scr[d] = wd;
    end
  endtask

  task automatic drive(input logic rn, input logic rd, input logic wr,
                       input logic [2:0] a, input logic [31:0] wd, input string tag);
    @(negedge clock);
    reset_n = rn;
    bus_a.read = rd; bus_a.write = wr; bus_a.address = a; bus_a.writedata = wd;
    bus_b.read = rd; bus_b.write = wr; bus_b.address = a; bus_b.writedata = wd;
    model_step(rn, rd, wr, a, wd, tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, "idle");
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, "reset");
  endtask

  task automatic rd_word(input logic [2:0] a, input string tag);
    drive(1'b1, 1'b1, 1'b0, a, 32'd0, tag);
  endtask

  task automatic wr_word(input logic [2:0] a, input logic [31:0] wd);
    drive(1'b1, 1'b0, 1'b1, a, wd, "write");
  endtask

  task automatic check_port(input int w, input bit rst, input logic v, input logic [31:0] d);
    exp_t e;
    bit   have;
    have = (w == 0) ? (q_a.size() > 0) : (q_b.size() > 0);
    if (have) e = (w == 0) ? q_a[0] : q_b[0];
    total++;
    if (rst) begin
      if (v !== 1'b0 || d !== 32'd0) begin
        bad++;
        $display("FAIL reset_out dut%0d: valid=%b data=%h, expected valid=0 data=0", w, v, d);
      end
      last_d[w] = 32'd0;
    end else if (v === 1'b1) begin
      if (!have) begin
        bad++;
        $display("FAIL unexpected_valid dut%0d cyc=%0d: data=%h, expected no response", w, cyc, d);
      end else begin
        if (w == 0) void'(q_a.pop_front());
        else        void'(q_b.pop_front());
        if ((e.cyc + 1) != cyc || d !== e.val) begin
          bad++;
          $display("FAIL %s dut%0d: got data=%h at cyc %0d, expected data=%h at cyc %0d",
                   e.tag, w, d, cyc, e.val, e.cyc + 1);
        end
        last_d[w] = e.val;
      end
    end else if (v === 1'b0) begin
      if (have && (e.cyc + 1) <= cyc) begin
        if (w == 0) void'(q_a.pop_front());
        else        void'(q_b.pop_front());
        bad++;
        $display("FAIL %s dut%0d: no readdatavalid at cyc %0d, expected data=%h", e.tag, w, cyc, e.val);
      end else if (d !== last_d[w]) begin
        bad++;
        $display("FAIL hold dut%0d cyc=%0d: readdata=%h, expected held %h", w, cyc, d, last_d[w]);
      end
    end else begin
      bad++;
      $display("FAIL valid_x dut%0d cyc=%0d: readdatavalid=%b, expected 0 or 1", w, cyc, v);
    end
  endtask

  // Response monitor: samples both instances just after every rising edge.
  always begin
    @(posedge clock);
    rst_seen = !reset_n;
    #1;
    check_port(0, rst_seen, bus_a.readdatavalid, bus_a.readdata);
    check_port(1, rst_seen, bus_b.readdatavalid, bus_b.readdata);
  end

  initial begin
    #400000;
    $display("FAIL timeout: run did not complete, expected completion");
    $fatal(1);
  end

  initial begin
    bit found;
    bus_a.read = 1'b0; bus_a.write = 1'b0; bus_a.address = 3'd0; bus_a.writedata = 32'd0;
    bus_b.read = 1'b0; bus_b.write = 1'b0; bus_b.address = 3'd0; bus_b.writedata = 32'd0;
    do_reset(3);

    // ID and timestamp straight after reset, then the first counter value.
    rd_word(3'd0, "id");
    rd_word(3'd1, "timestamp");
    rd_word(3'd2, "uptime_start");
    idle(2);

    // Scratch write followed by back-to-back reads, including an unmapped word.
    wr_word(3'd4, 32'hDEADBEEF);
    rd_word(3'd4, "scratch_rd1");
    rd_word(3'd4, "scratch_rd2");
    rd_word(3'd6, "unmapped_rd");
    drive(1'b1, 1'b1, 1'b1, 3'd4, 32'h12345678, "rd_wr_same_cycle");
    rd_word(3'd4, "scratch_after_rw");
    wr_word(3'd0, 32'hFFFFFFFF);
    rd_word(3'd0, "id_write_ignored");
    idle(1);

    // Wrap of the 8-bit counter sets OVF; writing 5 clears it.
    do_reset(2);
    idle(260);
    rd_word(3'd5, "ctrl_after_wrap");
    wr_word(3'd5, 32'h5);
    rd_word(3'd5, "ctrl_ovf_cleared");

    // CLR issued exactly on the wrap cycle of the 8-bit counter.
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (m_cnt[0] == 64'd255 && m_en[0]) found = 1'b1;
      else idle(1);
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL wrap_wait: wrap cycle not reached, expected within 300 cycles");
    end
    wr_word(3'd5, 32'h3);
    rd_word(3'd2, "lo_after_clr_on_wrap");
    rd_word(3'd5, "ctrl_no_ovf_on_clr");

    // Stop, clear, preset the 40-bit counter above 2^32, then check the HI snapshot.
    wr_word(3'd5, 32'h0);
    wr_word(3'd5, 32'h2);
    @(negedge clock);
    force dut_b.cnt_r = 40'h01_0000_0003;
    bus_a.read = 1'b0; bus_a.write = 1'b0;
    bus_b.read = 1'b0; bus_b.write = 1'b0;
    model_step(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, "idle");
    m_cnt[1] = 64'h1_0000_0003;
    @(posedge clock);
    #1;
    release dut_b.cnt_r;
    rd_word(3'd2, "uptime_lo_preset");
    wr_word(3'd5, 32'h1);
    idle(20);
    rd_word(3'd3, "uptime_hi_snapshot");
    rd_word(3'd2, "uptime_lo_running");

    // Read in the reset cycle is dropped, and scratch is cleared.
    wr_word(3'd4, 32'hAABBCCDD);
    idle(1);
    drive(1'b0, 1'b1, 1'b0, 3'd4, 32'd0, "read_in_reset");
    rd_word(3'd4, "scratch_after_reset");
    idle(2);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
            3'($urandom_range(0, 7)), 32'($urandom), "random");
    end
    idle(3);

    total++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      bad++;
      $display("FAIL pending: %0d/%0d responses outstanding, expected 0/0", q_a.size(), q_b.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
